// File: rtl/game_board_renderer.sv
// Overlays an N x N game board (cell codes, grid lines, cursor frame) onto the VGA pixel stream.
// Two-cycle pipeline. Define CURSOR_BLINK_EN to make the cursor frame blink every BLINK_FRAMES frames.
module game_board_renderer #(
  parameter int          MAX_CELLS    = 16,
  parameter int          CELL_LOG2    = 5,
  parameter int          ORIGIN_X     = 64,
  parameter int          ORIGIN_Y     = 32,
  parameter int          CODE_W       = 5,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] GRID_RGB     = 12'h444,
  parameter logic [11:0] CURSOR_RGB   = 12'hFF0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           is_game_on,
  input  logic [$clog2(MAX_CELLS):0]                     board_size,
  input  logic [MAX_CELLS-1:0][MAX_CELLS-1:0][CODE_W-1:0] board,
  input  logic [$clog2(MAX_CELLS)-1:0]                   cursor_col,
  input  logic [$clog2(MAX_CELLS)-1:0]                   cursor_row,
  input  logic [10:0]                                    bus_in_hcount,
  input  logic [10:0]                                    bus_in_vcount,
  input  logic                                           bus_in_hsync,
  input  logic                                           bus_in_vsync,
  input  logic                                           bus_in_hblnk,
  input  logic                                           bus_in_vblnk,
  input  logic [11:0]                                    bus_in_rgb,
  output logic [10:0]                                    bus_out_hcount,
  output logic [10:0]                                    bus_out_vcount,
  output logic                                           bus_out_hsync,
  output logic                                           bus_out_vsync,
  output logic                                           bus_out_hblnk,
  output logic                                           bus_out_vblnk,
  output logic [11:0]                                    bus_out_rgb
);

  localparam int IDX_W = $clog2(MAX_CELLS);
  localparam int N_W   = IDX_W + 1;
  localparam int HW    = 11;
  localparam int CELL  = 1 << CELL_LOG2;

  // Frame-start detection and board size latch
  logic           vblnk_q;
  logic           vblnk_rise;
  logic [N_W-1:0] n_r;
  logic [N_W-1:0] size_clamped;

  assign vblnk_rise   = bus_in_vblnk & ~vblnk_q;
  assign size_clamped = (board_size > N_W'(MAX_CELLS)) ? N_W'(MAX_CELLS) : board_size;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      n_r     <= '0;
    end else begin
      vblnk_q <= bus_in_vblnk;
      if (vblnk_rise) n_r <= size_clamped;
    end
  end

  logic cursor_on;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (vblnk_rise) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign cursor_on = blink_phase;
`else
  // Blink period has no meaning without the blink counter.
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_FRAMES;
  assign cursor_on        = 1'b1;
`endif

  // Stage 1: board-relative coordinates
  logic [HW-1:0] dx;
  logic [HW-1:0] dy;
  logic [HW-1:0] board_px;
  logic          inside_c;

  always_comb begin
    dx       = bus_in_hcount - HW'(ORIGIN_X);
    dy       = bus_in_vcount - HW'(ORIGIN_Y);
    board_px = HW'(n_r) << CELL_LOG2;
    inside_c = (bus_in_hcount >= HW'(ORIGIN_X)) && (bus_in_vcount >= HW'(ORIGIN_Y)) &&
               (dx < board_px) && (dy < board_px);
  end

  logic [HW-1:0]        s1_hcount;
  logic [HW-1:0]        s1_vcount;
  logic                 s1_hsync;
  logic                 s1_vsync;
  logic                 s1_hblnk;
  logic                 s1_vblnk;
  logic [11:0]          s1_rgb;
  logic                 s1_inside;
  logic [IDX_W-1:0]     s1_col;
  logic [IDX_W-1:0]     s1_row;
  logic [CELL_LOG2-1:0] s1_offx;
  logic [CELL_LOG2-1:0] s1_offy;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_rgb    <= '0;
      s1_inside <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_offx   <= '0;
      s1_offy   <= '0;
    end else begin
      s1_hcount <= bus_in_hcount;
      s1_vcount <= bus_in_vcount;
      s1_hsync  <= bus_in_hsync;
      s1_vsync  <= bus_in_vsync;
      s1_hblnk  <= bus_in_hblnk;
      s1_vblnk  <= bus_in_vblnk;
      s1_rgb    <= bus_in_rgb;
      s1_inside <= inside_c;
      s1_col    <= dx[CELL_LOG2 +: IDX_W];
      s1_row    <= dy[CELL_LOG2 +: IDX_W];
      s1_offx   <= dx[CELL_LOG2-1:0];
      s1_offy   <= dy[CELL_LOG2-1:0];
    end
  end

  // Two outermost pixel rings on each side of a cell form the cursor frame.
  function automatic logic near_edge(input logic [CELL_LOG2-1:0] off);
    return (off <= CELL_LOG2'(1)) || (off >= CELL_LOG2'(CELL - 2));
  endfunction

  // Stage 2: colour selection
  logic [CODE_W-1:0] code;
  logic [4:0]        c5;
  logic [11:0]       cell_rgb;
  logic              cursor_hit;
  logic [11:0]       rgb_next;

  always_comb begin
    code       = board[s1_row][s1_col];
    c5         = 5'(code);
    cell_rgb   = {c5[3:0], ~c5[3:0], c5[4] ? 4'hF : 4'h0};
    cursor_hit = cursor_on &&
                 (N_W'(cursor_row) < n_r) && (N_W'(cursor_col) < n_r) &&
                 (s1_row == cursor_row) && (s1_col == cursor_col) &&
                 (near_edge(s1_offx) || near_edge(s1_offy));
    rgb_next   = s1_rgb;
    if (s1_hblnk || s1_vblnk)
      rgb_next = '0;
    else if (!is_game_on || !s1_inside)
      rgb_next = s1_rgb;
    else if (cursor_hit)
      rgb_next = CURSOR_RGB;
    else if ((s1_offx == '0) || (s1_offy == '0))
      rgb_next = GRID_RGB;
    else if (code == '0)
      rgb_next = s1_rgb;
    else
      rgb_next = cell_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out_hcount <= '0;
      bus_out_vcount <= '0;
      bus_out_hsync  <= 1'b0;
      bus_out_vsync  <= 1'b0;
      bus_out_hblnk  <= 1'b0;
      bus_out_vblnk  <= 1'b0;
      bus_out_rgb    <= '0;
    end else begin
      bus_out_hcount <= s1_hcount;
      bus_out_vcount <= s1_vcount;
      bus_out_hsync  <= s1_hsync;
      bus_out_vsync  <= s1_vsync;
      bus_out_hblnk  <= s1_hblnk;
      bus_out_vblnk  <= s1_vblnk;
      bus_out_rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_game_board_renderer.sv
// Randomized bench for game_board_renderer against a per-pixel reference model of the board overlay.
module tb_game_board_renderer;

  localparam int MAXC = 16;
  localparam int CL   = 5;
  localparam int CELL = 1 << CL;
  localparam int OX   = 64;
  localparam int OY   = 32;
  localparam int CW   = 5;
`ifdef CURSOR_BLINK_EN
  localparam int BF   = 2;
`else
  localparam int BF   = 30;
`endif
  localparam logic [11:0] GRID = 12'h444;
  localparam logic [11:0] CUR  = 12'hFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                 rst;
  logic                                 is_game_on;
  logic [4:0]                           board_size;
  logic [MAXC-1:0][MAXC-1:0][CW-1:0]    board;
  logic [3:0]                           cursor_col, cursor_row;
  logic [10:0]                          bus_in_hcount, bus_in_vcount;
  logic                                 bus_in_hsync, bus_in_vsync, bus_in_hblnk, bus_in_vblnk;
  logic [11:0]                          bus_in_rgb;
  logic [10:0]                          bus_out_hcount, bus_out_vcount;
  logic                                 bus_out_hsync, bus_out_vsync, bus_out_hblnk, bus_out_vblnk;
  logic [11:0]                          bus_out_rgb;
  logic [25:0]                          tim_out;

  assign tim_out = {bus_out_hcount, bus_out_vcount, bus_out_hsync, bus_out_vsync,
                    bus_out_hblnk, bus_out_vblnk};

  game_board_renderer #(
    .MAX_CELLS(MAXC), .CELL_LOG2(CL), .ORIGIN_X(OX), .ORIGIN_Y(OY), .CODE_W(CW),
    .BLINK_FRAMES(BF), .GRID_RGB(GRID), .CURSOR_RGB(CUR)
  ) dut (
    .clk(clk), .rst(rst), .is_game_on(is_game_on), .board_size(board_size), .board(board),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .bus_in_hcount(bus_in_hcount), .bus_in_vcount(bus_in_vcount),
    .bus_in_hsync(bus_in_hsync), .bus_in_vsync(bus_in_vsync),
    .bus_in_hblnk(bus_in_hblnk), .bus_in_vblnk(bus_in_vblnk), .bus_in_rgb(bus_in_rgb),
    .bus_out_hcount(bus_out_hcount), .bus_out_vcount(bus_out_vcount),
    .bus_out_hsync(bus_out_hsync), .bus_out_vsync(bus_out_vsync),
    .bus_out_hblnk(bus_out_hblnk), .bus_out_vblnk(bus_out_vblnk), .bus_out_rgb(bus_out_rgb)
  );

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int cells [MAXC][MAXC];
  int n_mdl;
  bit prev_vb;
  int frames;

  typedef struct {
    int          hc, vc;
    logic [25:0] tim;
    logic [11:0] rgb;
    logic [11:0] rin;
    int          fix_mode;   // 0 none, 1 constant, 2 equals input rgb
    logic [11:0] fix;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  function automatic bit cursor_visible();
`ifdef CURSOR_BLINK_EN
    return ((frames / BF) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] model_rgb(input int hc, input int vc, input bit hb, input bit vb,
                                            input logic [11:0] rin);
    int dx, dy, row, col, ox, oy, c;
    bit cur;
    if (hb || vb) return 12'h000;
    if (!is_game_on) return rin;
    dx = hc - OX;
    dy = vc - OY;
    if (dx < 0 || dy < 0 || dx >= n_mdl * CELL || dy >= n_mdl * CELL) return rin;
    col = dx / CELL;  row = dy / CELL;
    ox  = dx % CELL;  oy  = dy % CELL;
    cur = cursor_visible() && int'(cursor_row) < n_mdl && int'(cursor_col) < n_mdl &&
          row == int'(cursor_row) && col == int'(cursor_col) &&
          (ox < 2 || ox >= CELL - 2 || oy < 2 || oy >= CELL - 2);
    if (cur) return CUR;
    if (ox == 0 || oy == 0) return GRID;
    c = cells[row][col];
    if (c == 0) return rin;
    return 12'(((c & 15) << 8) | (((~c) & 15) << 4) | (((c >> 4) & 1) != 0 ? 15 : 0));
  endfunction

  task automatic load_board();
    for (int r = 0; r < MAXC; r++)
      for (int c = 0; c < MAXC; c++)
        board[r][c] = CW'(cells[r][c]);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check($sformatf("rgb@%0d,%0d", e.hc, e.vc), 32'(bus_out_rgb), 32'(e.rgb));
    check($sformatf("timing@%0d,%0d", e.hc, e.vc), 32'(tim_out), 32'(e.tim));
    if (e.fix_mode == 1) check(t, 32'(bus_out_rgb), 32'(e.fix));
    else if (e.fix_mode == 2) check(t, 32'(bus_out_rgb), 32'(e.rin));
  endtask

  task automatic step(input int hc, input int vc, input bit hb, input bit vb,
                      input string tag, input int fix_mode, input logic [11:0] fix);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 2) pop_check();
    bus_in_hcount = 11'(hc);
    bus_in_vcount = 11'(vc);
    bus_in_hsync  = 1'($urandom);
    bus_in_vsync  = 1'($urandom);
    bus_in_hblnk  = hb;
    bus_in_vblnk  = vb;
    bus_in_rgb    = 12'($urandom);
    e.hc       = hc;
    e.vc       = vc;
    e.tim      = {11'(hc), 11'(vc), bus_in_hsync, bus_in_vsync, hb, vb};
    e.rin      = bus_in_rgb;
    e.rgb      = model_rgb(hc, vc, hb, vb, bus_in_rgb);
    e.fix_mode = fix_mode;
    e.fix      = fix;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (vb && !prev_vb) begin
      n_mdl = (int'(board_size) > MAXC) ? MAXC : int'(board_size);
      frames++;
    end
    prev_vb = vb;
  endtask

  task automatic px(input int hc, input int vc);
    step(hc, vc, 1'b0, 1'b0, "", 0, 12'h000);
  endtask

  // Two blank pixels so that control changes never land on a pixel still in flight.
  task automatic quiesce();
    repeat (2) step(0, 0, 1'b1, 1'b0, "", 0, 12'h000);
  endtask

  task automatic frame_start();
    repeat (3) step(0, 600, 1'b1, 1'b1, "", 0, 12'h000);
    step(0, 0, 1'b1, 1'b0, "", 0, 12'h000);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      pop_check();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus_in_hcount = 11'h3A5;
    bus_in_vcount = 11'h15A;
    bus_in_hsync  = 1'b1;
    bus_in_vsync  = 1'b1;
    bus_in_hblnk  = 1'b1;
    bus_in_vblnk  = 1'b0;
    bus_in_rgb    = 12'hABC;
    exp_q.delete();
    tag_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_rgb", 32'(bus_out_rgb), 32'h0);
      check("rst_timing", 32'(tim_out), 32'h0);
    end
    n_mdl   = 0;
    prev_vb = 1'b0;
    frames  = 0;
    rst     = 1'b0;
  endtask

  task automatic rand_px();
    int hc, vc;
    bit hb, vb;
    if ($urandom_range(0, 7) == 0) begin
      hc = $urandom_range(0, 2047);
      vc = $urandom_range(0, 2047);
    end else begin
      hc = $urandom_range(40, 600);
      vc = $urandom_range(20, 560);
    end
    hb = ($urandom_range(0, 15) == 0);
    vb = ($urandom_range(0, 127) == 0);
    step(hc, vc, hb, vb, "", 0, 12'h000);
  endtask

  initial begin
    rst = 1'b1;
    is_game_on = 1'b1;
    board_size = 5'd8;
    cursor_col = 4'd3;
    cursor_row = 4'd3;
    bus_in_hcount = '0; bus_in_vcount = '0;
    bus_in_hsync = 1'b0; bus_in_vsync = 1'b0; bus_in_hblnk = 1'b0; bus_in_vblnk = 1'b0;
    bus_in_rgb = '0;
    for (int r = 0; r < MAXC; r++)
      for (int c = 0; c < MAXC; c++)
        cells[r][c] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
    cells[0][0] = 5'h03;
    load_board();
    n_mdl = 0; prev_vb = 1'b0; frames = 0;

    do_reset();

    // Board hidden until the first frame start after reset
    for (int i = 0; i < 6; i++)
      step(70 + i * 50, 40 + i * 45, 1'b0, 1'b0, "pre_vblnk_pass", 2, 12'h000);

    frame_start();
    step(96, 32, 1'b0, 1'b0, "grid_96_32", 1, GRID);
    step(70, 40, 1'b0, 1'b0, "code03", 1, 12'h3C0);
    quiesce();
    cells[0][0] = 5'h13;
    load_board();
    step(70, 40, 1'b0, 1'b0, "code13", 1, 12'h3CF);

    // Size change mid-frame takes effect only at the next frame
    board_size = 5'd4;
    px(64 + 4 * 32 + 1, 100);
    frame_start();
    step(64 + 4 * 32 + 1, 40, 1'b0, 1'b0, "shrunk_outside", 2, 12'h000);
    px(64 + 3 * 32 + 5, 40);

    quiesce();
    board_size = 5'd8;
    cursor_col = 4'd2;
    cursor_row = 4'd1;
    for (int f = 0; f < 4; f++) begin
      frame_start();
`ifdef CURSOR_BLINK_EN
      px(64 + 64 + 1, 32 + 32 + 5);
`else
      step(64 + 64 + 1, 32 + 32 + 5, 1'b0, 1'b0, "cursor_frame", 1, CUR);
`endif
      px(64 + 64 + 10, 32 + 32 + 10);
    end

    quiesce();
    is_game_on = 1'b0;
    step(64 + 64 + 1, 32 + 32 + 5, 1'b0, 1'b0, "game_off", 2, 12'h000);
    quiesce();
    is_game_on = 1'b1;
    step(64 + 64 + 10, 32 + 32 + 10, 1'b1, 1'b0, "hblnk_inside", 1, 12'h000);

    // Oversized request clamps to MAX_CELLS
    quiesce();
    board_size = 5'd20;
    cells[15][15] = 5'h1F;
    load_board();
    cursor_col = 4'd0;
    cursor_row = 4'd0;
    frame_start();
    step(64 + 511, 32 + 511, 1'b0, 1'b0, "clamp_inside", 1, 12'hF0F);
    step(64 + 512, 40, 1'b0, 1'b0, "clamp_outside", 2, 12'h000);

    for (int round = 0; round < 8; round++) begin
      quiesce();
      for (int r = 0; r < MAXC; r++)
        for (int c = 0; c < MAXC; c++)
          cells[r][c] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      load_board();
      cursor_col = 4'($urandom);
      cursor_row = 4'($urandom);
      board_size = 5'($urandom_range(0, 20));
      is_game_on = ($urandom_range(0, 7) != 0);
      frame_start();
      for (int i = 0; i < 300; i++) begin
        if (round == 4 && i == 150) begin
          do_reset();
          for (int k = 0; k < 4; k++)
            step(70 + k * 60, 40 + k * 50, 1'b0, 1'b0, "post_reset_hidden", 2, 12'h000);
        end
        rand_px();
      end
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/game_board_renderer.md
# game_board_renderer

Parametrised VGA pipeline stage that overlays an N×N game board onto the incoming pixel stream. Each board cell is a fixed power-of-two square; its colour comes from a per-cell code array, with grid lines and an optional blinking cursor frame. Sits in the VGA chain after the background stage and before the mouse/cursor overlay. Adds a fixed two-cycle latency to every bus signal.

## Interface
Parameters:
- MAX_CELLS, 16, maximum cells per board side; power of two.
- CELL_LOG2, 5, log2 of cell edge in pixels (32 px).
- ORIGIN_X, 64, hcount of board's left edge.
- ORIGIN_Y, 32, vcount of board's top edge.
- CODE_W, 5, bits per cell code.
- BLINK_FRAMES, 30, frames per cursor blink half-period.
- GRID_RGB, 12'h444, grid line colour.
- CURSOR_RGB, 12'hFF0, cursor frame colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- is_game_on  in  1  enables board overlay.
- board_size  in  $clog2(MAX_CELLS)+1  requested N; 0 = no board, >MAX_CELLS clamps to MAX_CELLS.
- board  in  [CODE_W-1:0] [MAX_CELLS-1:0][MAX_CELLS-1:0]  cell codes, indexed [row][col].
- cursor_col, cursor_row  in  $clog2(MAX_CELLS) each  selected cell.
- bus_in  vga_bus  -  upstream timing (hcount, vcount, hsync, vsync, hblnk, vblnk) and rgb.
- bus_out  vga_bus  -  same fields, delayed two cycles, rgb replaced as below.

## Operation
- Board size latch: n_r captures clamped board_size on bus_in.vblnk rising edge (vblnk=1, previous cycle 0). Mid-frame board_size changes have no visible effect until the next frame.
- Stage 1 (registered):
  - dx = hcount−ORIGIN_X, dy = vcount−ORIGIN_Y.
  - inside = hcount≥ORIGIN_X, vcount≥ORIGIN_Y, dx < n_r<<CELL_LOG2, dy < n_r<<CELL_LOG2.
  - col = dx>>CELL_LOG2, row = dy>>CELL_LOG2.
  - offx/offy = low CELL_LOG2 bits of dx/dy.
  - Timing fields and rgb copied.
- Stage 2 (registered output), priority order:
  1. hblnk or vblnk → rgb 0.
  2. !is_game_on or !inside → delayed bus_in.rgb.
  3. Cursor frame active and (row,col)==(cursor_row,cursor_col) and offx or offy ∈ {0,1,CELL−2,CELL−1} → CURSOR_RGB.
  4. offx==0 or offy==0 → GRID_RGB.
  5. code c = board[row][col]; c==0 → delayed bus_in.rgb; else {c[3:0], ~c[3:0], c[4]?4'hF:4'h0} (upper code bits ignored if CODE_W>5).
- Right/bottom closing grid line is not drawn; the board ends at the last cell pixel.
- Cursor row/col ≥ n_r: no cursor drawn.

## Timing
- Latency exactly 2 clk for all bus_out fields; no back-pressure, one pixel per clock.
- Reset: all bus_out fields 0; n_r=0; blink counter 0; blink phase 1 (visible).
- Blink counter increments on each vblnk rising edge. On reaching BLINK_FRAMES−1 it wraps to 0 and the phase toggles. Phase changes only at frame start.
- Reset asserted mid-frame: outputs 0 on the next edge. The board is hidden until the first vblnk rise after reset releases.

## Configuration
- CURSOR_BLINK_EN defined: cursor frame is drawn only while phase=1 (blinks every BLINK_FRAMES frames).
- CURSOR_BLINK_EN not defined: blink counter is omitted and the cursor frame is always active.

## Test plan
Test parameters: CELL_LOG2=5, ORIGIN 64/32.
- Reset with board_size=8, then run to first vblnk rise. Before the rise: bus_out.rgb equals bus_in.rgb from 2 cycles earlier everywhere. After the rise: pixel (96,32) = GRID_RGB.
- board[0][0]=5'h03, n=8, cursor at (3,3), pixel (70,40) → rgb 12'h3C0. Same pixel with code 5'h13 → 12'h3CF.
- board_size changed 8→4 at vcount 100. That frame still draws 8 cells; the next frame's pixel (64+4*32+1, 40) passes bus_in.rgb.
- Cursor (2,1), n=8, pixel (64+64+1, 32+32+5) → CURSOR_RGB. With CURSOR_BLINK_EN and BLINK_FRAMES=2, it alternates CURSOR_RGB/cell colour every 2 frames.
- is_game_on=0, or hblnk=1 inside board: delayed bus_in.rgb, and 0 respectively. hsync/vsync are exactly 2-cycle delayed copies.
- board_size=20 → clamped to 16; pixel (64+511, 32+511) inside, (64+512, 40) outside.
